adc_scan_ctrl: RTL and testbench
================================

Name: adc_scan_ctrl

Overview:
Parametrised LTC2308-class SPI ADC controller and the successor to the single-channel interface. It scans a programmable set of channels in ascending order, either continuously or as one-shot passes. Its SCK is a true divided clock rather than a gated system clock. It accounts for the ADC's one-frame config/result pipeline and delivers channel-tagged samples on a valid/ready stream with overrun detection. It sits between the ADC pins and the display/processing logic.

Parameters:
NUM_CH, 8, number of scannable channels (1..8); CH_W = max(1, $clog2(NUM_CH)).
DATA_W, 12, bits shifted per frame and result width.
CONV_CYCLES, 3, clk cycles ADC_CONVST is held high; must cover tCONV at the clk rate.
SCK_HALF, 1, clk cycles per ADC_SCK half-period (>=1).
GAP_CYCLES, 1, idle clk cycles between frames (>=1).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  continuous-scan mode while high
start  in  1  single-cycle pulse; runs one scan pass when not enabled
chan_mask  in  NUM_CH  bit i set = channel i in scan
unipolar  in  1  UNI bit of config word
busy  out  1  high from frame start until controller returns to IDLE
res_valid  out  1  sample available
res_ready  in  1  consumer accepts sample
res_data  out  DATA_W  conversion result, MSB first as received
res_chan  out  CH_W  channel res_data belongs to
overrun  out  1  sticky; a sample was overwritten before acceptance
clear_overrun  in  1  clears overrun
ADC_CONVST  out  1  conversion start
ADC_SCK  out  1  serial clock
ADC_SDI  out  1  config data to ADC
ADC_SDO  in  1  result data from ADC

Behaviour:
- Reset: all outputs 0; state IDLE; pipeline-valid flag cleared; holding register cleared. Reset mid-frame aborts immediately. The next frame after reset is a priming frame.
- States: IDLE -> CONV -> SHIFT -> GAP -> (CONV | IDLE).
- IDLE:
  - Exit to CONV when enable=1 and chan_mask!=0, or when a start pulse arrives with chan_mask!=0.
  - Latch chan_mask and unipolar on exit; they are re-latched only at the start of each new pass.
  - A start pulse with mask 0, or while busy, is ignored.
- CONV:
  - ADC_CONVST=1 for exactly CONV_CYCLES clk cycles; SCK and SDI are 0.
- SHIFT:
  - ADC_CONVST=0. DATA_W SCK periods, each 2*SCK_HALF clk cycles, starting low.
  - ADC_SDI is updated when SCK falls (and before the first rise), MSB first.
  - ADC_SDO is sampled on the clk edge where SCK rises.
  - Config word: {1'b1, ch[0], ch[2:1], unipolar, 1'b0}, zero-padded to DATA_W.
- GAP:
  - GAP_CYCLES cycles, all pins low.
  - Publish the result, then pick the next channel: next set mask bit above the current one, wrapping to the lowest.
- Pipeline:
  - The result shifted in frame N belongs to the channel configured in frame N-1.
  - res_chan is that previous channel.
  - The priming frame result (no previous config) is discarded.
- Pass accounting:
  - A single-shot pass with K mask bits runs K+1 frames. The final frame re-sends the last channel's config, then returns to IDLE.
  - Continuous mode: when enable drops, the current frame finishes, one flush frame runs, then IDLE.
  - enable rising while a single pass runs converts it to continuous mode.
- Output stream:
  - res_valid is set in the GAP publish cycle.
  - Contents are held stable while res_valid=1 and res_ready=0.
  - Handshake completes on res_valid & res_ready.
  - Publish while still valid and not accepted: overwrite, keep res_valid=1, set overrun.
  - Publish in the same cycle as acceptance: no overrun.
  - clear_overrun in the same cycle as a new overrun: set wins.
- busy=1 in CONV/SHIFT/GAP.

Decomposition:
- Package adc_pkg holds:
  - the state enum;
  - the config-word field positions (SD, OS, S1, S0, UNI, SLP);
  - function chan_to_cfg(ch, uni) returning the 6-bit word;
  - function next_chan(mask, cur).
- Sub-module adc_sck_gen: SCK_HALF divider. Outputs sck, rise_stb and fall_stb, plus a bit counter with a done strobe, enabled only in SHIFT.

Test Plan:
- Reset hold 3 cycles -> all outputs 0, busy=0. Release with enable=0 -> no CONVST for 100 cycles.
- enable=1, mask=8'h01, ADC model returns 12'hABC:
  - first frame discarded;
  - afterwards res_valid pulses with res_data=12'hABC, res_chan=0;
  - SDI bits 1,0,0,0,unipolar,0 per frame.
- start pulse, mask=8'h29, model returns 12'h100+ch:
  - 4 frames;
  - outputs (ch0,12'h100), (ch3,12'h103), (ch5,12'h105);
  - then IDLE, busy=0.
- res_ready=0 across two publishes -> second sample visible, overrun=1. clear_overrun -> overrun=0.
- Reset asserted mid-SHIFT (bit 5) -> pins 0 next cycle. After restart, first frame discarded and correct tagging resumes.
- start with mask=0 -> ignored. SCK_HALF=3 build -> SCK period 6 clk cycles and data still correct.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and helpers for the LTC2308-class scanning ADC controller.
// Holds the FSM state type, the config-word layout and channel-selection functions.
package adc_pkg;

  typedef enum logic [1:0] {StIdle, StConv, StShift, StGap} state_e;

  localparam int unsigned MaxCh = 8;
  localparam int unsigned CfgW  = 6;

  // Bit positions inside the 6-bit config word, MSB shifted first
  localparam int unsigned CfgSd  = 5;
  localparam int unsigned CfgOs  = 4;
  localparam int unsigned CfgS1  = 3;
  localparam int unsigned CfgS0  = 2;
  localparam int unsigned CfgUni = 1;
  localparam int unsigned CfgSlp = 0;

  function automatic logic [CfgW-1:0] chan_to_cfg(input logic [2:0] ch, input logic uni);
    logic [CfgW-1:0] w;
    w         = '0;
    w[CfgSd]  = 1'b1;
    w[CfgOs]  = ch[0];
    w[CfgS1]  = ch[2];
    w[CfgS0]  = ch[1];
    w[CfgUni] = uni;
    w[CfgSlp] = 1'b0;
    return w;
  endfunction

  // Next set mask bit above cur, wrapping to the lowest; returns cur if it is the only one.
  function automatic logic [2:0] next_chan(input logic [MaxCh-1:0] mask, input logic [2:0] cur);
    logic [2:0] idx;
    logic       found;
    logic [2:0] res;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= MaxCh; i++) begin
      idx = cur + 3'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// Divided serial clock for the ADC frame: SCK_HALF clk cycles per half period,
// starting low, with edge strobes and an end-of-frame strobe after DATA_W periods.
module adc_sck_gen #(
  parameter int unsigned SCK_HALF = 1,
  parameter int unsigned DATA_W   = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb,
  output logic done
);

  localparam int unsigned HalfW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int unsigned BitW  = $clog2(DATA_W);

  logic [HalfW-1:0] half_q;
  logic [BitW-1:0]  bit_q;
  logic             sck_q;
  logic             half_end;

  assign half_end = en && (half_q == HalfW'(SCK_HALF - 1));
  assign rise_stb = half_end && !sck_q;
  assign fall_stb = half_end && sck_q;
  assign done     = fall_stb && (bit_q == BitW'(DATA_W - 1));
  assign sck      = sck_q;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      half_q <= '0;
      bit_q  <= '0;
      sck_q  <= 1'b0;
    end else if (half_end) begin
      half_q <= '0;
      sck_q  <= ~sck_q;
      if (fall_stb) bit_q <= bit_q + 1'b1;
    end else begin
      half_q <= half_q + 1'b1;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Multi-channel scanning controller for an LTC2308-class SPI ADC. Handles the one-frame
// config/result pipeline and presents channel-tagged samples on a valid/ready stream.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned CONV_CYCLES = 3,
  parameter int unsigned SCK_HALF    = 1,
  parameter int unsigned GAP_CYCLES  = 1,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              unipolar,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [CH_W-1:0]   res_chan,
  output logic              overrun,
  input  logic              clear_overrun,
  output logic              ADC_CONVST,
  output logic              ADC_SCK,
  output logic              ADC_SDI,
  input  logic              ADC_SDO
);

  state_e            state_q;
  logic [15:0]       cnt_q;
  logic [MaxCh-1:0]  mask_q;
  logic              uni_q;
  logic              cont_q;
  logic              flush_q;
  logic              pipe_vld_q;
  logic [2:0]        cur_ch_q;
  logic [2:0]        prev_ch_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              convst_q;
  logic              sdi_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;
  logic [CH_W-1:0]   res_chan_q;
  logic              overrun_q;

  logic              sck;
  logic              rise_stb;
  logic              fall_stb;
  logic              done;
  logic [MaxCh-1:0]  mask_in;
  logic [DATA_W-1:0] cfg_word;
  logic [2:0]        nxt_cur;
  logic [2:0]        nxt_new;
  logic              wrap;

  adc_sck_gen #(
    .SCK_HALF(SCK_HALF),
    .DATA_W  (DATA_W)
  ) u_sck_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q == StShift),
    .sck     (sck),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb),
    .done    (done)
  );

  assign mask_in = MaxCh'(chan_mask);
  assign nxt_cur = next_chan(mask_q, cur_ch_q);
  assign nxt_new = next_chan(mask_in, 3'd7);
  // No set bit above the current channel: this frame closed the pass
  assign wrap    = (nxt_cur <= cur_ch_q);

  always_comb begin
    cfg_word = '0;
    cfg_word[DATA_W-1 -: CfgW] = chan_to_cfg(cur_ch_q, uni_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mask_q      <= '0;
      uni_q       <= 1'b0;
      cont_q      <= 1'b0;
      flush_q     <= 1'b0;
      pipe_vld_q  <= 1'b0;
      cur_ch_q    <= '0;
      prev_ch_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      convst_q    <= 1'b0;
      sdi_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_chan_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (res_valid_q && res_ready) res_valid_q <= 1'b0;
      if (clear_overrun) overrun_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if ((enable || start) && (chan_mask != '0)) begin
            mask_q     <= mask_in;
            uni_q      <= unipolar;
            cont_q     <= enable;
            flush_q    <= 1'b0;
            pipe_vld_q <= 1'b0;
            cur_ch_q   <= nxt_new;
            cnt_q      <= '0;
            convst_q   <= 1'b1;
            state_q    <= StConv;
          end
        end
        StConv: begin
          if (cnt_q == 16'(CONV_CYCLES - 1)) begin
            convst_q <= 1'b0;
            sdi_q    <= cfg_word[DATA_W-1];
            tx_q     <= cfg_word << 1;
            state_q  <= StShift;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StShift: begin
          if (rise_stb) rx_q <= {rx_q[DATA_W-2:0], ADC_SDO};
          if (done) begin
            sdi_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StGap;
            // Data shifted this frame answers the previous frame's config
            if (pipe_vld_q) begin
              res_data_q  <= rx_q;
              res_chan_q  <= prev_ch_q[CH_W-1:0];
              res_valid_q <= 1'b1;
              if (res_valid_q && !res_ready) overrun_q <= 1'b1;
            end
            pipe_vld_q <= 1'b1;
            prev_ch_q  <= cur_ch_q;
          end else if (fall_stb) begin
            sdi_q <= tx_q[DATA_W-1];
            tx_q  <= tx_q << 1;
          end
        end
        StGap: begin
          if (cnt_q == 16'(GAP_CYCLES - 1)) begin
            cnt_q    <= '0;
            state_q  <= StConv;
            convst_q <= 1'b1;
            if (flush_q) begin
              state_q  <= StIdle;
              convst_q <= 1'b0;
            end else if (cont_q || enable) begin
              cont_q <= 1'b1;
              if (!enable) begin
                flush_q <= 1'b1;
              end else if (!wrap) begin
                cur_ch_q <= nxt_cur;
              end else if (chan_mask != '0) begin
                mask_q   <= mask_in;
                uni_q    <= unipolar;
                cur_ch_q <= nxt_new;
              end else begin
                flush_q <= 1'b1;
              end
            end else if (!wrap) begin
              cur_ch_q <= nxt_cur;
            end else begin
              // Re-send the last config so its result comes back in one more frame
              flush_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = (state_q != StIdle);
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_chan   = res_chan_q;
  assign overrun    = overrun_q;
  assign ADC_CONVST = convst_q;
  assign ADC_SCK    = sck;
  assign ADC_SDI    = sdi_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl with a behavioural pipelined ADC model;
// a second instance with SCK_HALF=3 checks the divided SCK timing.
module tb_adc_scan_ctrl;

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } sample_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, start, unipolar, res_ready, clear_overrun, adc_sdo;
  logic [7:0]  chan_mask;
  logic        busy, res_valid, overrun, adc_convst, adc_sck, adc_sdi;
  logic [11:0] res_data;
  logic [2:0]  res_chan;

  logic        enable3, start3, sdo3;
  logic [7:0]  mask3;
  logic        busy3, valid3, overrun3, convst3, sck3, sdi3;
  logic [11:0] data3;
  logic [2:0]  chan3;

  adc_scan_ctrl #(
    .NUM_CH(8), .DATA_W(12), .CONV_CYCLES(3), .SCK_HALF(1), .GAP_CYCLES(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .chan_mask(chan_mask),
    .unipolar(unipolar), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_chan(res_chan), .overrun(overrun),
    .clear_overrun(clear_overrun), .ADC_CONVST(adc_convst), .ADC_SCK(adc_sck),
    .ADC_SDI(adc_sdi), .ADC_SDO(adc_sdo)
  );

  adc_scan_ctrl #(
    .NUM_CH(8), .DATA_W(12), .CONV_CYCLES(3), .SCK_HALF(3), .GAP_CYCLES(1)
  ) dut3 (
    .clk(clk), .reset(reset), .enable(enable3), .start(start3), .chan_mask(mask3),
    .unipolar(1'b0), .busy(busy3), .res_valid(valid3), .res_ready(1'b1),
    .res_data(data3), .res_chan(chan3), .overrun(overrun3),
    .clear_overrun(1'b0), .ADC_CONVST(convst3), .ADC_SCK(sck3),
    .ADC_SDI(sdi3), .ADC_SDO(sdo3)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  // Scoreboards and monitors
  sample_t exp_q[$];
  sample_t exp3_q[$];
  int popped = 0;
  int popped3 = 0;

  always @(negedge clk) begin : mon
    sample_t e;
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sample: got ch%0d %0h expected none", res_chan, res_data);
      end else begin
        e = exp_q.pop_front();
        check("sample_chan", 32'(res_chan), 32'(e.ch));
        check("sample_data", 32'(res_data), 32'(e.data));
      end
      popped++;
    end
  end

  always @(negedge clk) begin : mon3
    sample_t e;
    if (!reset && valid3) begin
      if (exp3_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sample3: got ch%0d %0h expected none", chan3, data3);
      end else begin
        e = exp3_q.pop_front();
        check("sample3_chan", 32'(chan3), 32'(e.ch));
        check("sample3_data", 32'(data3), 32'(e.data));
      end
      popped3++;
    end
  end

  int convst_cycles = 0;
  int busy_cycles = 0;
  int rise_total = 0;
  always @(negedge clk) begin
    if (adc_convst === 1'b1) convst_cycles++;
    if (busy === 1'b1) busy_cycles++;
  end

  // Pipelined ADC model: result of frame N answers the config received in frame N-1
  logic [11:0] model_val[8];
  logic [11:0] sdo_sh;
  logic [11:0] cfg_sh = '0;
  int          rise_cnt = 0;
  logic [2:0]  prev_cfg_ch = '0;
  logic        prev_cfg_ok = 1'b0;
  logic [11:0] cfg_seen[$];

  always @(posedge adc_convst) begin
    if (rise_cnt != 12) prev_cfg_ok = 1'b0;
    sdo_sh   = prev_cfg_ok ? model_val[prev_cfg_ch] : 12'hFFF;
    rise_cnt = 0;
  end
  always @(negedge adc_convst) adc_sdo = sdo_sh[11];
  always @(negedge adc_sck) begin
    sdo_sh  = sdo_sh << 1;
    adc_sdo = sdo_sh[11];
  end
  always @(posedge adc_sck) begin
    cfg_sh = {cfg_sh[10:0], adc_sdi};
    rise_cnt++;
    rise_total++;
    if (rise_cnt == 12) begin
      cfg_seen.push_back(cfg_sh);
      prev_cfg_ch = {cfg_sh[9], cfg_sh[8], cfg_sh[10]};
      prev_cfg_ok = 1'b1;
    end
  end

  // Second model returns a fixed word and records SCK edge times
  logic [11:0] sh3;
  longint      rise_t3[$];
  longint      fall_t3[$];
  always @(negedge convst3) begin
    sh3  = 12'h5A5;
    sdo3 = sh3[11];
  end
  always @(negedge sck3) begin
    sh3  = sh3 << 1;
    sdo3 = sh3[11];
    fall_t3.push_back(longint'($time));
  end
  always @(posedge sck3) rise_t3.push_back(longint'($time));

  task automatic wait_pops(input int target, input string name);
    int n = 0;
    while (popped < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (popped < target) timeout_fail(name);
  endtask

  task automatic wait_busy(input logic val, input string name);
    int n = 0;
    while (busy !== val && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== val) timeout_fail(name);
  endtask

  task automatic pulse_start(input logic [7:0] mask);
    @(negedge clk);
    chan_mask = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int c0, b0, r0, n;
    reset = 1'b1; enable = 1'b0; start = 1'b0; unipolar = 1'b0; res_ready = 1'b1;
    clear_overrun = 1'b0; chan_mask = '0; adc_sdo = 1'b0;
    enable3 = 1'b0; start3 = 1'b0; mask3 = '0; sdo3 = 1'b0;
    for (int i = 0; i < 8; i++) model_val[i] = 12'h000;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({busy, res_valid, res_data, res_chan, overrun,
                                adc_convst, adc_sck, adc_sdi}), 32'h0);
    reset = 1'b0;
    c0 = convst_cycles;
    repeat (100) @(negedge clk);
    check("idle_no_convst", 32'(convst_cycles - c0), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);

    // Continuous scan of channel 0, unipolar; stop after four samples
    model_val[0] = 12'hABC;
    cfg_seen.delete();
    unipolar = 1'b1;
    repeat (5) exp_q.push_back('{ch: 3'd0, data: 12'hABC});
    @(negedge clk);
    chan_mask = 8'h01;
    enable = 1'b1;
    wait_pops(popped + 4, "cont_samples");
    enable = 1'b0;
    wait_busy(1'b0, "cont_idle");
    check("cont_queue_drained", 32'(exp_q.size()), 32'd0);
    check("cont_frames", 32'(cfg_seen.size()), 32'd6);
    for (int i = 0; i < cfg_seen.size(); i++) check("cont_cfg_word", 32'(cfg_seen[i]), 32'h880);

    // Single pass over channels 0,3,5
    for (int i = 0; i < 8; i++) model_val[i] = 12'h100 + 12'(i);
    unipolar = 1'b0;
    cfg_seen.delete();
    exp_q.push_back('{ch: 3'd0, data: 12'h100});
    exp_q.push_back('{ch: 3'd3, data: 12'h103});
    exp_q.push_back('{ch: 3'd5, data: 12'h105});
    c0 = convst_cycles;
    r0 = rise_total;
    pulse_start(8'h29);
    wait_busy(1'b1, "pass_busy");
    wait_busy(1'b0, "pass_idle");
    repeat (2) @(negedge clk);
    check("pass_queue_drained", 32'(exp_q.size()), 32'd0);
    check("pass_frames", 32'(cfg_seen.size()), 32'd4);
    if (cfg_seen.size() == 4) begin
      check("pass_cfg0", 32'(cfg_seen[0]), 32'h800);
      check("pass_cfg1", 32'(cfg_seen[1]), 32'hD00);
      check("pass_cfg2", 32'(cfg_seen[2]), 32'hE00);
      check("pass_cfg3", 32'(cfg_seen[3]), 32'hE00);
    end
    check("pass_convst_cycles", 32'(convst_cycles - c0), 32'd12);
    check("pass_sck_rises", 32'(rise_total - r0), 32'd48);
    check("pass_not_busy", 32'(busy), 32'd0);

    // Start with an empty mask is ignored
    c0 = convst_cycles;
    b0 = busy_cycles;
    pulse_start(8'h00);
    repeat (30) @(negedge clk);
    check("mask0_no_convst", 32'(convst_cycles - c0), 32'd0);
    check("mask0_no_busy", 32'(busy_cycles - b0), 32'd0);

    // Overrun: two publishes with the consumer stalled
    model_val[1] = 12'h211;
    model_val[2] = 12'h322;
    res_ready = 1'b0;
    pulse_start(8'h06);
    wait_busy(1'b1, "ovr_busy");
    wait_busy(1'b0, "ovr_idle");
    check("ovr_valid_held", 32'(res_valid), 32'd1);
    check("ovr_flag", 32'(overrun), 32'd1);
    exp_q.push_back('{ch: 3'd2, data: 12'h322});
    res_ready = 1'b1;
    wait_pops(popped + 1, "ovr_accept");
    @(negedge clk);
    check("ovr_valid_cleared", 32'(res_valid), 32'd0);
    check("ovr_still_sticky", 32'(overrun), 32'd1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Reset in the middle of a shift, then resume with correct tagging
    @(negedge clk);
    chan_mask = 8'h01;
    enable = 1'b1;
    n = 0;
    while (!(adc_convst === 1'b1) && n < 500) begin @(negedge clk); n++; end
    while (rise_cnt != 5 && n < 500) begin @(negedge clk); n++; end
    if (rise_cnt != 5) timeout_fail("midshift_reach");
    reset = 1'b1;
    @(negedge clk);
    check("midshift_pins", 32'({adc_convst, adc_sck, adc_sdi, busy}), 32'h0);
    check("midshift_valid", 32'(res_valid), 32'd0);
    model_val[2] = 12'h4A7;
    chan_mask = 8'h04;
    repeat (2) exp_q.push_back('{ch: 3'd2, data: 12'h4A7});
    @(negedge clk);
    reset = 1'b0;
    wait_pops(popped + 2, "restart_samples");
    enable = 1'b0;
    exp_q.push_back('{ch: 3'd2, data: 12'h4A7});
    wait_busy(1'b0, "restart_idle");
    repeat (2) @(negedge clk);
    check("restart_queue_drained", 32'(exp_q.size()), 32'd0);

    // SCK_HALF=3 instance: one pass on channel 2
    exp3_q.push_back('{ch: 3'd2, data: 12'h5A5});
    @(negedge clk);
    mask3 = 8'h04;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    n = 0;
    while (busy3 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (busy3 !== 1'b0) timeout_fail("sck3_idle");
    repeat (2) @(negedge clk);
    check("sck3_samples", 32'(popped3), 32'd1);
    check("sck3_rises", 32'(rise_t3.size()), 32'd24);
    if (rise_t3.size() >= 12 && fall_t3.size() >= 1) begin
      check("sck3_period", 32'(rise_t3[1] - rise_t3[0]), 32'd60);
      check("sck3_span", 32'(rise_t3[11] - rise_t3[0]), 32'd660);
      check("sck3_high", 32'(fall_t3[0] - rise_t3[0]), 32'd30);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
